// File: rtl/axi_cache_pkg.sv
// Shared types for the AXI write arbiter: FSM state encoding, latched AW control
// fields, and the AXI burst/response encodings.
package axi_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wr_state_t;

    // Width-independent part of an AW request; address and ID widths are module parameters.
    typedef struct packed {
        logic [1:0] burst;
        logic [2:0] size;
        logic [7:0] len;
    } aw_ctrl_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way arbiter with one-hot grant. Round-robin when AXI_WR_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 always winning.
module axi_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef AXI_WR_ARB_RR_EN
    // Starts at 1 so that a tie straight out of reset goes to requester 0.
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (advance && (|gnt)) begin
            last_gnt <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst_n, advance};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write-channel arbiter with outstanding-write limit and B routing.
// Optional macro AXI_WR_ARB_RR_EN selects round-robin instead of fixed s0 priority.
module axi_wr_arbiter
    import axi_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // requester 0
    input  logic                          s0_awvalid,
    input  logic [ADDR_WIDTH-1:0]         s0_awaddr,
    input  logic [ID_WIDTH-1:0]           s0_awid,
    input  logic [1:0]                    s0_awburst,
    input  logic [2:0]                    s0_awsize,
    input  logic [7:0]                    s0_awlen,
    output logic                          s0_awready,
    input  logic                          s0_wvalid,
    input  logic [DATA_WIDTH-1:0]         s0_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s0_wstrb,
    input  logic                          s0_wlast,
    output logic                          s0_wready,
    output logic                          s0_bvalid,
    output logic [1:0]                    s0_bresp,
    output logic [ID_WIDTH-1:0]           s0_bid,
    input  logic                          s0_bready,
    // requester 1
    input  logic                          s1_awvalid,
    input  logic [ADDR_WIDTH-1:0]         s1_awaddr,
    input  logic [ID_WIDTH-1:0]           s1_awid,
    input  logic [1:0]                    s1_awburst,
    input  logic [2:0]                    s1_awsize,
    input  logic [7:0]                    s1_awlen,
    output logic                          s1_awready,
    input  logic                          s1_wvalid,
    input  logic [DATA_WIDTH-1:0]         s1_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s1_wstrb,
    input  logic                          s1_wlast,
    output logic                          s1_wready,
    output logic                          s1_bvalid,
    output logic [1:0]                    s1_bresp,
    output logic [ID_WIDTH-1:0]           s1_bid,
    input  logic                          s1_bready,
    // downstream
    output logic                          m_awvalid,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic [ID_WIDTH:0]             m_awid,
    output logic [1:0]                    m_awburst,
    output logic [2:0]                    m_awsize,
    output logic [7:0]                    m_awlen,
    input  logic                          m_awready,
    output logic                          m_wvalid,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_wstrb,
    output logic                          m_wlast,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    input  logic [1:0]                    m_bresp,
    input  logic [ID_WIDTH:0]             m_bid,
    output logic                          m_bready,
    // debug visibility
    output logic [1:0]                    dbg_state,
    output logic [$clog2(MAX_OUTST+1)-1:0] dbg_outst
);

    // Handshakes on every channel are plain AXI: a transfer happens on a rising clk
    // edge where valid and ready are both high; valid never waits on ready.

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    wr_state_t             state, state_nxt;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    aw_ctrl_t              aw_ctrl_q;
    logic [CNT_W-1:0]      outst_cnt;
    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    logic                  arb_take;
    logic                  aw_hs;
    logic                  b_hs;

    // Requests only reach the arbiter in IDLE with room for another outstanding write.
    assign arb_req  = (state == IDLE && outst_cnt < CNT_MAX) ? {s1_awvalid, s0_awvalid} : 2'b00;
    assign arb_take = |arb_gnt;

    axi_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (arb_take),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_ctrl_q <= '0;
        end else if (arb_take) begin
            grant     <= arb_gnt[1];
            aw_addr_q <= arb_gnt[1] ? s1_awaddr : s0_awaddr;
            aw_id_q   <= arb_gnt[1] ? s1_awid   : s0_awid;
            aw_ctrl_q <= arb_gnt[1] ? '{burst: s1_awburst, size: s1_awsize, len: s1_awlen}
                                    : '{burst: s0_awburst, size: s0_awsize, len: s0_awlen};
        end
    end

    always_comb begin
        state_nxt  = state;
        m_awvalid  = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        m_wvalid   = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_take) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    s0_awready = ~grant;
                    s1_awready = grant;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                m_wvalid  = grant ? s1_wvalid : s0_wvalid;
                s0_wready = ~grant & m_wready;
                s1_wready = grant & m_wready;
                if (m_wvalid && m_wready && m_wlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_awaddr  = aw_addr_q;
    assign m_awid    = {grant, aw_id_q};
    assign m_awburst = aw_ctrl_q.burst;
    assign m_awsize  = aw_ctrl_q.size;
    assign m_awlen   = aw_ctrl_q.len;

    assign m_wdata = grant ? s1_wdata : s0_wdata;
    assign m_wstrb = grant ? s1_wstrb : s0_wstrb;
    assign m_wlast = grant ? s1_wlast : s0_wlast;

    // B path is purely combinational; the ID MSB carries the requester index.
    assign m_bready  = m_bid[ID_WIDTH] ? s1_bready : s0_bready;
    assign s0_bvalid = m_bvalid & ~m_bid[ID_WIDTH];
    assign s1_bvalid = m_bvalid &  m_bid[ID_WIDTH];
    assign s0_bid    = m_bid[ID_WIDTH-1:0];
    assign s1_bid    = m_bid[ID_WIDTH-1:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;

    assign aw_hs = m_awvalid & m_awready;
    assign b_hs  = m_bvalid & m_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_cnt <= '0;
        end else if (aw_hs && !b_hs && outst_cnt != CNT_MAX) begin
            outst_cnt <= outst_cnt + CNT_W'(1);
        end else if (b_hs && !aw_hs && outst_cnt != '0) begin
            outst_cnt <= outst_cnt - CNT_W'(1);
        end
    end

    assign dbg_state = state;
    assign dbg_outst = outst_cnt;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (default parameters).
module tb_axi_wr_arbiter;
    import axi_cache_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [1:0]  s_awvalid;
    logic [31:0] s_awaddr  [2];
    logic [3:0]  s_awid    [2];
    logic [1:0]  s_awburst [2];
    logic [2:0]  s_awsize  [2];
    logic [7:0]  s_awlen   [2];
    wire  [1:0]  s_awready;
    logic [1:0]  s_wvalid;
    logic [63:0] s_wdata   [2];
    logic [7:0]  s_wstrb   [2];
    logic [1:0]  s_wlast;
    wire  [1:0]  s_wready;
    wire  [1:0]  s_bvalid;
    wire  [1:0]  s_bresp   [2];
    wire  [3:0]  s_bid     [2];
    logic [1:0]  s_bready;

    wire         m_awvalid;
    wire  [31:0] m_awaddr;
    wire  [4:0]  m_awid;
    wire  [1:0]  m_awburst;
    wire  [2:0]  m_awsize;
    wire  [7:0]  m_awlen;
    logic        m_awready;
    wire         m_wvalid;
    wire  [63:0] m_wdata;
    wire  [7:0]  m_wstrb;
    wire         m_wlast;
    logic        m_wready;
    logic        m_bvalid;
    logic [1:0]  m_bresp;
    logic [4:0]  m_bid;
    wire         m_bready;
    wire  [1:0]  dbg_state;
    wire  [2:0]  dbg_outst;

    int checks = 0;
    int errors = 0;

    axi_wr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_awvalid(s_awvalid[0]), .s0_awaddr(s_awaddr[0]), .s0_awid(s_awid[0]),
        .s0_awburst(s_awburst[0]), .s0_awsize(s_awsize[0]), .s0_awlen(s_awlen[0]),
        .s0_awready(s_awready[0]),
        .s0_wvalid(s_wvalid[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
        .s0_wlast(s_wlast[0]), .s0_wready(s_wready[0]),
        .s0_bvalid(s_bvalid[0]), .s0_bresp(s_bresp[0]), .s0_bid(s_bid[0]), .s0_bready(s_bready[0]),
        .s1_awvalid(s_awvalid[1]), .s1_awaddr(s_awaddr[1]), .s1_awid(s_awid[1]),
        .s1_awburst(s_awburst[1]), .s1_awsize(s_awsize[1]), .s1_awlen(s_awlen[1]),
        .s1_awready(s_awready[1]),
        .s1_wvalid(s_wvalid[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
        .s1_wlast(s_wlast[1]), .s1_wready(s_wready[1]),
        .s1_bvalid(s_bvalid[1]), .s1_bresp(s_bresp[1]), .s1_bid(s_bid[1]), .s1_bready(s_bready[1]),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awburst(m_awburst),
        .m_awsize(m_awsize), .m_awlen(m_awlen), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
        .dbg_state(dbg_state), .dbg_outst(dbg_outst)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic init_inputs;
        rst_n = 1'b0;
        s_awvalid = 2'b00; s_wvalid = 2'b00; s_wlast = 2'b00; s_bready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awid[i] = '0; s_awburst[i] = BURST_INCR;
            s_awsize[i] = 3'd3; s_awlen[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY; m_bid = '0;
    endtask

    // driver: wait (bounded) for the FSM to present an AW downstream
    task automatic wait_addr(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg_state !== ADDR && n < 20);
        checks++;
        if (dbg_state !== ADDR) begin
            errors++;
            $display("FAIL %s_grant_timeout: state=%0d required=%0d", name, dbg_state, ADDR);
        end
    endtask

    // driver: one single-beat write from requester p, checking AW and W mirroring
    task automatic single_write(input int p, input logic [31:0] addr, input logic [3:0] id);
        logic [4:0]  exp_id;
        logic [63:0] exp_data;
        exp_id   = {p[0], id};
        exp_data = {32'hA5A5_0000, addr};
        s_awaddr[p] = addr; s_awid[p] = id; s_awlen[p] = 8'd0;
        s_awvalid[p] = 1'b1; m_awready = 1'b1;
        wait_addr("single");
        checks++;
        if (s_awready[p] !== 1'b1 || m_awid !== exp_id || m_awaddr !== addr) begin
            errors++;
            $display("FAIL single_aw: awready=%b awid=%h addr=%h required 1 %h %h",
                     s_awready[p], m_awid, m_awaddr, exp_id, addr);
        end
        @(negedge clk);
        s_awvalid[p] = 1'b0; m_awready = 1'b0;
        s_wvalid[p] = 1'b1; s_wdata[p] = exp_data; s_wstrb[p] = 8'hFF; s_wlast[p] = 1'b1;
        m_wready = 1'b1;
        #1;
        checks++;
        if (m_wvalid !== 1'b1 || m_wdata !== exp_data || m_wlast !== 1'b1 || s_wready[p] !== 1'b1) begin
            errors++;
            $display("FAIL single_w: wvalid=%b wdata=%h wlast=%b wready=%b required 1 %h 1 1",
                     m_wvalid, m_wdata, m_wlast, s_wready[p], exp_data);
        end
        @(negedge clk);
        s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; m_wready = 1'b0;
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL single_end_idle: state=%0d required=%0d", dbg_state, IDLE);
        end
    endtask

    // driver: n B responses with a fixed bid, checking the count steps down from start
    task automatic drain_b(input int n, input logic [4:0] bid, input int start);
        for (int j = 0; j < n; j++) begin
            m_bvalid = 1'b1; m_bid = bid; m_bresp = RESP_OKAY;
            @(negedge clk);
            checks++;
            if (int'(dbg_outst) !== start - j - 1) begin
                errors++;
                $display("FAIL drain_count: outst=%0d required=%0d", dbg_outst, start - j - 1);
            end
        end
        m_bvalid = 1'b0;
    endtask

    task automatic test_reset;
        init_inputs();
        s_awvalid = 2'b11; s_wvalid = 2'b11; m_wready = 1'b1; m_awready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || dbg_outst !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outst=%0d required 0 0", dbg_state, dbg_outst);
        end
        checks++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_valid: awvalid=%b wvalid=%b required 0 0", m_awvalid, m_wvalid);
        end
        checks++;
        if (s_awready !== 2'b00 || s_wready !== 2'b00) begin
            errors++;
            $display("FAIL reset_s_ready: awready=%b wready=%b required 00 00", s_awready, s_wready);
        end
        checks++;
        if (m_awaddr !== 32'd0 || m_awid !== 5'd0 || m_awlen !== 8'd0 || m_awburst !== 2'd0) begin
            errors++;
            $display("FAIL reset_aw_fields: addr=%h id=%h len=%h burst=%h required 0",
                     m_awaddr, m_awid, m_awlen, m_awburst);
        end
        init_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Both requesters ask continuously for 4-beat bursts.
    task automatic test_priority;
        int exp_p;
        logic [63:0] d;
        s_awid[0] = 4'h2; s_awid[1] = 4'h9;
        s_awlen[0] = 8'd3; s_awlen[1] = 8'd3;
        s_awaddr[0] = 32'h1000; s_awaddr[1] = 32'h2000;
        s_awvalid = 2'b11; m_awready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_WR_ARB_RR_EN
            exp_p = k % 2;
`else
            exp_p = 0;
`endif
            wait_addr("prio");
            checks++;
            if (m_awid !== {exp_p[0], (exp_p == 1) ? 4'h9 : 4'h2} || s_awready[exp_p] !== 1'b1
                || s_awready[1-exp_p] !== 1'b0) begin
                errors++;
                $display("FAIL prio_grant%0d: awid=%h awready=%b required port %0d", k, m_awid, s_awready, exp_p);
            end
            @(negedge clk);
            if (k == 3) s_awvalid = 2'b00;
            m_wready = 1'b1;
            for (int b = 0; b < 4; b++) begin
                d = {32'(k), 32'(b)};
                s_wvalid = 2'b11; s_wlast = 2'b00;
                s_wdata[exp_p] = d; s_wdata[1-exp_p] = ~d;
                s_wlast[exp_p] = (b == 3);
                #1;
                checks++;
                if (m_wdata !== d || m_wlast !== (b == 3) || s_wready[exp_p] !== 1'b1
                    || s_wready[1-exp_p] !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_beat%0d_%0d: wdata=%h wlast=%b wready=%b required %h %b port %0d",
                             k, b, m_wdata, m_wlast, s_wready, d, (b == 3), exp_p);
                end
                @(negedge clk);
            end
            s_wvalid = 2'b00; s_wlast = 2'b00; m_wready = 1'b0;
            checks++;
            if (dbg_state !== IDLE) begin
                errors++;
                $display("FAIL prio_wlast_end%0d: state=%0d required=%0d", k, dbg_state, IDLE);
            end
        end
        m_awready = 1'b0;
        checks++;
        if (dbg_outst !== 3'd4) begin
            errors++;
            $display("FAIL prio_outst: outst=%0d required=4", dbg_outst);
        end
        drain_b(4, 5'h02, 4);
        // one more B at zero must not wrap
        drain_b(1, 5'h02, 1);
    endtask

    task automatic test_single_write;
        single_write(0, 32'h100, 4'h5);
        checks++;
        if (dbg_outst !== 3'd1) begin
            errors++;
            $display("FAIL single_outst: outst=%0d required=1", dbg_outst);
        end
        s_bready = 2'b01; m_bvalid = 1'b1; m_bid = 5'h05; m_bresp = RESP_SLVERR;
        #1;
        checks++;
        if (s_bvalid !== 2'b01 || s_bid[0] !== 4'h5 || s_bresp[0] !== RESP_SLVERR || m_bready !== 1'b1) begin
            errors++;
            $display("FAIL b_route_s0: bvalid=%b bid=%h bresp=%b bready=%b required 01 5 10 1",
                     s_bvalid, s_bid[0], s_bresp[0], m_bready);
        end
        @(negedge clk);
        checks++;
        if (dbg_outst !== 3'd0) begin
            errors++;
            $display("FAIL single_b_outst: outst=%0d required=0", dbg_outst);
        end
        m_bid = 5'h13;
        #1;
        checks++;
        if (s_bvalid !== 2'b10 || s_bid[1] !== 4'h3 || m_bready !== 1'b0) begin
            errors++;
            $display("FAIL b_route_s1: bvalid=%b bid=%h bready=%b required 10 3 0", s_bvalid, s_bid[1], m_bready);
        end
        m_bvalid = 1'b0; s_bready = 2'b11; m_bresp = RESP_OKAY;
        @(negedge clk);
    endtask

    // Outstanding limit, stall in ADDR, and simultaneous AW/B handshakes.
    task automatic test_max_outst;
        for (int i = 0; i < 4; i++) single_write(1, 32'h300 + 32'(i * 16), 4'h7);
        s_awaddr[1] = 32'h400; s_awid[1] = 4'h7; s_awlen[1] = 8'd0; s_awvalid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dbg_state !== IDLE || s_awready[1] !== 1'b0 || dbg_outst !== 3'd4) begin
                errors++;
                $display("FAIL full_no_grant%0d: state=%0d awready=%b outst=%0d required 0 0 4",
                         i, dbg_state, s_awready[1], dbg_outst);
            end
            @(negedge clk);
        end
        m_bvalid = 1'b1; m_bid = 5'h17;
        #1;
        checks++;
        if (m_bready !== 1'b1 || s_bvalid !== 2'b10) begin
            errors++;
            $display("FAIL full_b: bready=%b bvalid=%b required 1 10", m_bready, s_bvalid);
        end
        @(negedge clk);
        m_bvalid = 1'b0;
        checks++;
        if (dbg_state !== IDLE || dbg_outst !== 3'd3) begin
            errors++;
            $display("FAIL full_after_b: state=%0d outst=%0d required 0 3", dbg_state, dbg_outst);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ADDR) begin
            errors++;
            $display("FAIL full_resume: state=%0d required=%0d", dbg_state, ADDR);
        end
        // stall: one B drains during the stall, then hold off for several more cycles
        m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_awaddr[1] = 32'hDEAD_0000 + 32'(i);
            s_awlen[1] = 8'hFF;
            #1;
            checks++;
            if (m_awvalid !== 1'b1 || m_awaddr !== 32'h400 || m_awid !== 5'h17 || m_awlen !== 8'd0
                || s_awready[1] !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable%0d: awvalid=%b addr=%h id=%h len=%h awready=%b required 1 400 17 0 0",
                         i, m_awvalid, m_awaddr, m_awid, m_awlen, s_awready[1]);
            end
            @(negedge clk);
        end
        checks++;
        if (dbg_outst !== 3'd2) begin
            errors++;
            $display("FAIL stall_outst: outst=%0d required=2", dbg_outst);
        end
        m_awready = 1'b1; m_bvalid = 1'b1;
        #1;
        checks++;
        if (s_awready !== 2'b10) begin
            errors++;
            $display("FAIL stall_accept: awready=%b required=10", s_awready);
        end
        @(negedge clk);
        m_awready = 1'b0; m_bvalid = 1'b0; s_awvalid[1] = 1'b0;
        #1;
        checks++;
        if (dbg_outst !== 3'd2 || dbg_state !== DATA || s_awready !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_hs: outst=%0d state=%0d awready=%b required 2 2 00",
                     dbg_outst, dbg_state, s_awready);
        end
        s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1; m_wready = 1'b1;
        @(negedge clk);
        s_wvalid[1] = 1'b0; s_wlast[1] = 1'b0; m_wready = 1'b0;
        drain_b(2, 5'h17, 2);
    endtask

    task automatic test_reset_mid_burst;
        s_awaddr[0] = 32'h800; s_awid[0] = 4'h3; s_awlen[0] = 8'd7;
        s_awvalid[0] = 1'b1; m_awready = 1'b1;
        wait_addr("mid");
        @(negedge clk);
        s_awvalid[0] = 1'b0; m_awready = 1'b0;
        s_wvalid[0] = 1'b1; s_wlast[0] = 1'b0; s_wdata[0] = 64'd1; m_wready = 1'b1;
        @(negedge clk);
        s_wdata[0] = 64'd2;
        #1;
        checks++;
        if (m_wvalid !== 1'b1 || m_wdata !== 64'd2 || dbg_outst !== 3'd1) begin
            errors++;
            $display("FAIL mid_beat2: wvalid=%b wdata=%h outst=%0d required 1 2 1", m_wvalid, m_wdata, dbg_outst);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || dbg_outst !== 3'd0 || m_wvalid !== 1'b0 || s_wready !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: state=%0d outst=%0d wvalid=%b wready=%b required 0 0 0 00",
                     dbg_state, dbg_outst, m_wvalid, s_wready);
        end
        m_bvalid = 1'b1; m_bid = 5'h03;
        #1;
        checks++;
        if (s_bvalid !== 2'b01 || m_bready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_b: bvalid=%b bready=%b required 01 1", s_bvalid, m_bready);
        end
        m_bvalid = 1'b0; s_wvalid[0] = 1'b0; m_wready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        single_write(1, 32'h900, 4'hC);
        checks++;
        if (dbg_outst !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_outst: outst=%0d required=1", dbg_outst);
        end
        drain_b(1, 5'h1C, 1);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_single_write();
        test_max_outst();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameters ADDR_WIDTH (default 32, address bits), DATA_WIDTH (default 64, data bits) and ID_WIDTH (default 4, requester ID bits).
REQ-002 SHALL have parameter MAX_OUTST (default 4, maximum outstanding writes awaiting B).
REQ-003 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset), in that order; reset rst_n is asynchronous, active-low; clock clk.
REQ-004 SHALL have, per requester port sN (N=0,1), AW inputs sN_awvalid 1, sN_awaddr ADDR_WIDTH, sN_awid ID_WIDTH, sN_awburst 2, sN_awsize 3 and sN_awlen 8.
REQ-005 SHALL have output sN_awready (1, AW accept to sN).
REQ-006 SHALL have inputs sN_wvalid 1, sN_wdata DATA_WIDTH, sN_wstrb DATA_WIDTH/8 and sN_wlast 1, plus output sN_wready (1, W accept to sN).
REQ-007 SHALL have outputs sN_bvalid 1, sN_bresp 2 and sN_bid ID_WIDTH, plus input sN_bready (1, write response handshake to sN).
REQ-008 SHALL have downstream AW outputs m_awvalid 1, m_awaddr ADDR_WIDTH, m_awid ID_WIDTH+1, m_awburst 2, m_awsize 3 and m_awlen 8, plus input m_awready 1.
REQ-009 SHALL have downstream W outputs m_wvalid 1, m_wdata DATA_WIDTH, m_wstrb DATA_WIDTH/8 and m_wlast 1, plus input m_wready 1.
REQ-010 SHALL have downstream B inputs m_bvalid 1, m_bresp 2 and m_bid ID_WIDTH+1, plus output m_bready 1.

Function
REQ-011 SHALL run an FSM with states IDLE, ADDR and DATA; reset state is IDLE.
REQ-012 IDLE: when any sN_awvalid is high and the outstanding count is below MAX_OUTST, SHALL register the grant index, latch that requester's AW fields, and enter ADDR the next cycle.
REQ-013 IDLE with the outstanding count equal to MAX_OUTST SHALL grant nothing and hold all sN_awready low.
REQ-014 ADDR: SHALL drive m_awvalid high with the latched fields and m_awid = {grant, sN_awid}.
REQ-015 ADDR: on the m_awvalid&m_awready cycle, SHALL pulse the granted sN_awready high for that same cycle, increment the count, and enter DATA.
REQ-016 The latched AW fields SHALL stay stable while m_awvalid is high and m_awready is low.
REQ-017 DATA: m_w* SHALL combinationally mirror the granted sN_w*, with sN_wready = m_wready; the non-granted sN_wready SHALL be 0.
REQ-018 DATA: on a handshake with m_wlast high, the FSM SHALL return to IDLE; a new grant needs at least one IDLE cycle, so an AW-to-AW gap is at least 3 cycles.
REQ-019 DATA: W beats SHALL NOT be counted; wlast alone ends the burst.
REQ-020 B routing: m_bid[ID_WIDTH] SHALL select the target sN; sN_bid = m_bid[ID_WIDTH-1:0], sN_bresp = m_bresp and sN_bvalid = m_bvalid; m_bready SHALL be the selected sN_bready; the other sN_bvalid SHALL be 0.
REQ-021 The outstanding count SHALL be $clog2(MAX_OUTST+1) bits: +1 on an m_aw handshake, -1 on an m_b handshake, unchanged when both occur in the same cycle, and never wrapping.
REQ-022 An sN_awvalid that drops before its grant SHALL be a protocol violation with undefined behaviour; no recovery logic.

Reset
REQ-023 While rst_n is low: FSM=IDLE, count=0, grant=0, latched AW fields=0, and m_awvalid, m_wvalid and all sN_awready/sN_wready low.
REQ-024 Reset asserted mid-burst SHALL abandon the burst without any drain; sN_bvalid and m_bready remain combinational pass-throughs.

Configuration
REQ-025 With macro AXI_WR_ARB_RR_EN defined: round-robin arbitration; priority SHALL go to the requester not granted last, and a simultaneous request after reset SHALL favour s0.
REQ-026 Without AXI_WR_ARB_RR_EN: fixed priority with s0 always winning; there SHALL be no last-grant register.

Structure
REQ-027 Package axi_cache_pkg SHALL hold the FSM state enum (IDLE/ADDR/DATA), an AW-field struct typedef, and the AXI burst and resp localparams.
REQ-028 Sub-module axi_rr_arb2 (2-way arbiter, request in, one-hot grant out, advance input) SHALL be instantiated; it degenerates to fixed priority without the macro.

Verification
REQ-029 s0 single-beat write addr 0x100 len 0, m_awready high -> m_awid=0x0_? with MSB 0, one W beat, back to IDLE, s0_bvalid when m_bid MSB=0.
REQ-030 With RR enabled, s0 and s1 both requesting continuously, 4-beat bursts -> grants alternate s0,s1,s0,s1, each burst ending on wlast.
REQ-031 MAX_OUTST=4, B withheld -> the 5th AW is not granted and sN_awready stays low; one m_bvalid&m_bready -> the grant resumes the next cycle.
REQ-032 m_aw and m_b handshakes in the same cycle at count=2 -> count stays 2.
REQ-033 m_awready low for 5 cycles in ADDR -> m_aw* stable and sN_awready low, then a single-cycle pulse on the accept.
REQ-034 rst_n asserted at the 2nd beat of an 8-beat burst -> the next cycle shows IDLE, count 0 and m_wvalid 0; a new request after release is granted normally.
